// File: rtl/fpu_pkg.sv
// +----------------------------------------------------------------------+
// | fpu_pkg: opcodes, controller states and a float pack helper.         |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
`default_nettype none

package fpu_pkg;

  typedef enum logic [3:0] {
    FADD = 4'd1,
    FSUB = 4'd2,
    FMUL = 4'd3,
    FDIV = 4'd4,
    FABS = 4'd5,
    FEQ  = 4'd6,
    FNE  = 4'd7,
    FLT  = 4'd8
  } fpu_op_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_RESP = 2'd2
  } ctrl_state_e;

  localparam int EXP_BIAS = 127;

  // Saturates to infinity on overflow and flushes to signed zero on underflow.
  function automatic logic [31:0] fp_pack(input logic s, input int e, input logic [23:0] m);
    logic [31:0] r;
    if (e >= 255) begin
      r = {s, 8'hFF, 23'd0};
    end else if (e <= 0) begin
      r = {s, 31'd0};
    end else begin
      r = {s, e[7:0], m[22:0]};
    end
    return r;
  endfunction

endpackage

`default_nettype wire

// File: rtl/fp_alu.sv
// +----------------------------------------------------------------------+
// | fp_alu: single-cycle combinational binary32 ALU (truncating).        |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
`default_nettype none

module fp_alu
  import fpu_pkg::*;
(
  input  logic [3:0]  op,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic [31:0] result,
  output logic        cmp
);

  // Subnormal operands are flushed to zero.
  logic        a_zero, b_zero, a_nan, b_nan;
  logic [23:0] ma, mb;
  assign a_zero = (a[30:23] == 8'd0);
  assign b_zero = (b[30:23] == 8'd0);
  assign a_nan  = (&a[30:23]) && (|a[22:0]);
  assign b_nan  = (&b[30:23]) && (|b[22:0]);
  assign ma     = a_zero ? 24'd0 : {1'b1, a[22:0]};
  assign mb     = b_zero ? 24'd0 : {1'b1, b[22:0]};

  logic        sbe, swap, s_big, s_small, hit;
  logic [7:0]  e_big, e_small, diff;
  logic [23:0] m_big, m_small, norm_m;
  logic [27:0] al_small, sum;
  int          lz;
  logic [31:0] add_res;

  always_comb begin
    sbe  = b[31] ^ (op == FSUB);
    swap = b[30:0] > a[30:0];
    if (swap) begin
      {s_big, e_big, m_big}       = {sbe, b[30:23], mb};
      {s_small, e_small, m_small} = {a[31], a[30:23], ma};
    end else begin
      {s_big, e_big, m_big}       = {a[31], a[30:23], ma};
      {s_small, e_small, m_small} = {sbe, b[30:23], mb};
    end
    diff     = e_big - e_small;
    al_small = (diff > 8'd26) ? 28'd0 : ({1'b0, m_small, 3'b000} >> diff);
    sum      = (s_big == s_small) ? ({1'b0, m_big, 3'b000} + al_small)
                                  : ({1'b0, m_big, 3'b000} - al_small);
    hit = 1'b0;
    lz  = 0;
    for (int i = 26; i >= 0; i--) begin
      if (!hit && sum[i]) begin
        hit = 1'b1;
        lz  = 26 - i;
      end
    end
    norm_m = 24'((sum << lz) >> 3);
    if (sum == 28'd0) begin
      add_res = 32'd0;
    end else if (sum[27]) begin
      add_res = fp_pack(s_big, int'(e_big) + 1, sum[27:4]);
    end else begin
      add_res = fp_pack(s_big, int'(e_big) - lz, norm_m);
    end
  end

  logic        s_md;
  logic [24:0] prod_hi, quo;
  int          e_mul, e_div;
  logic [31:0] mul_res, div_res;

  always_comb begin
    s_md    = a[31] ^ b[31];
    prod_hi = 25'(({24'd0, ma} * {24'd0, mb}) >> 23);
    e_mul   = int'(a[30:23]) + int'(b[30:23]) - EXP_BIAS + (prod_hi[24] ? 1 : 0);
    mul_res = (a_zero || b_zero) ? {s_md, 31'd0}
            : fp_pack(s_md, e_mul, prod_hi[24] ? prod_hi[24:1] : prod_hi[23:0]);
    quo     = b_zero ? 25'd0 : 25'({ma, 24'd0} / {24'd0, mb});
    e_div   = int'(a[30:23]) - int'(b[30:23]) + EXP_BIAS - (quo[24] ? 0 : 1);
    if (b_zero) begin
      div_res = {s_md, 8'hFF, 23'd0};
    end else if (a_zero) begin
      div_res = {s_md, 31'd0};
    end else begin
      div_res = fp_pack(s_md, e_div, quo[24] ? quo[24:1] : quo[23:0]);
    end
  end

  logic feq, flt;

  always_comb begin
    feq = !a_nan && !b_nan && ((a == b) || (a_zero && b_zero));
    if (a_nan || b_nan || (a_zero && b_zero)) begin
      flt = 1'b0;
    end else if (a[31] != b[31]) begin
      flt = a[31];
    end else if (!a[31]) begin
      flt = a[30:0] < b[30:0];
    end else begin
      flt = a[30:0] > b[30:0];
    end
    result = 32'd0;
    cmp    = 1'b0;
    case (op)
      FADD, FSUB: result = add_res;
      FMUL:       result = mul_res;
      FDIV:       result = div_res;
      FABS:       result = {1'b0, a[30:0]};
      FEQ:        cmp    = feq;
      FNE:        cmp    = !feq;
      FLT:        cmp    = flt;
      default:    ;
    endcase
  end

endmodule

`default_nettype wire

// File: rtl/rr_arbiter.sv
// +----------------------------------------------------------------------+
// | rr_arbiter: combinational round-robin pick starting after last_grant.|
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
`default_nettype none

module rr_arbiter #(
  parameter int NUM_REQ = 4,
  localparam int IDX_W = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IDX_W-1:0]   last_grant,
  output logic [NUM_REQ-1:0] grant,
  output logic [IDX_W-1:0]   grant_idx
);

  int   cand;
  logic found;

  always_comb begin
    grant     = '0;
    grant_idx = '0;
    found     = 1'b0;
    cand      = 0;
    for (int i = 1; i <= NUM_REQ; i++) begin
      cand = (int'(last_grant) + i) % NUM_REQ;
      if (!found && req[cand]) begin
        found       = 1'b1;
        grant[cand] = 1'b1;
        grant_idx   = IDX_W'(cand);
      end
    end
  end

endmodule

`default_nettype wire

// File: rtl/fpu_share_ctrl.sv
// +----------------------------------------------------------------------+
// | fpu_share_ctrl: round-robin shared access to one FP ALU, holding     |
// | operands for an op-dependent multicycle window. Revision: 1.0        |
// +----------------------------------------------------------------------+
`default_nettype none

module fpu_share_ctrl
  import fpu_pkg::*;
#(
  parameter int NUM_REQ    = 4,
  parameter int DIV_CYCLES = 4,
  parameter int ALU_CYCLES = 1
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [NUM_REQ-1:0]       req_valid,
  output logic [NUM_REQ-1:0]       req_ready,
  input  logic [NUM_REQ-1:0][3:0]  req_op,
  input  logic [NUM_REQ-1:0][31:0] req_op1,
  input  logic [NUM_REQ-1:0][31:0] req_op2,
  output logic [NUM_REQ-1:0]       resp_valid,
  output logic [31:0]              resp_result,
  output logic                     resp_cmp,
  output logic                     busy
);

  localparam int IDX_W      = $clog2(NUM_REQ);
  localparam int MAX_CYCLES = (DIV_CYCLES > ALU_CYCLES) ? DIV_CYCLES : ALU_CYCLES;
  localparam int CNT_W      = (MAX_CYCLES > 1) ? $clog2(MAX_CYCLES) : 1;
  localparam logic [CNT_W-1:0] DIV_LOAD = CNT_W'(DIV_CYCLES - 1);
  localparam logic [CNT_W-1:0] ALU_LOAD = CNT_W'(ALU_CYCLES - 1);

  ctrl_state_e      state_q, state_d;
  logic [IDX_W-1:0] last_grant_q, last_grant_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic [3:0]       op_q, op_d;
  logic [31:0]      op1_q, op1_d, op2_q, op2_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [31:0]      result_q, result_d;
  logic             cmp_q, cmp_d;

  logic [NUM_REQ-1:0] grant;
  logic [IDX_W-1:0]   grant_idx;
  logic [31:0]        alu_result;
  logic               alu_cmp;

  rr_arbiter #(.NUM_REQ(NUM_REQ)) u_arb (
    .req        (req_valid),
    .last_grant (last_grant_q),
    .grant      (grant),
    .grant_idx  (grant_idx)
  );

  // Fed only from the operand registers, so FDIV paths can be multicycled.
  fp_alu u_alu (
    .op     (op_q),
    .a      (op1_q),
    .b      (op2_q),
    .result (alu_result),
    .cmp    (alu_cmp)
  );

  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    idx_d        = idx_q;
    op_d         = op_q;
    op1_d        = op1_q;
    op2_d        = op2_q;
    cnt_d        = cnt_q;
    result_d     = result_q;
    cmp_d        = cmp_q;
    case (state_q)
      ST_IDLE: begin
        if (|req_valid) begin
          idx_d   = grant_idx;
          op_d    = req_op[grant_idx];
          op1_d   = req_op1[grant_idx];
          op2_d   = req_op2[grant_idx];
          cnt_d   = (req_op[grant_idx] == FDIV) ? DIV_LOAD : ALU_LOAD;
          state_d = ST_EXEC;
        end
      end
      ST_EXEC: begin
        if (cnt_q == '0) begin
          result_d = alu_result;
          cmp_d    = alu_cmp;
          state_d  = ST_RESP;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      ST_RESP: begin
        last_grant_d = idx_q;
        state_d      = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      last_grant_q <= IDX_W'(NUM_REQ - 1);
      idx_q        <= '0;
      op_q         <= '0;
      op1_q        <= '0;
      op2_q        <= '0;
      cnt_q        <= '0;
      result_q     <= '0;
      cmp_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      idx_q        <= idx_d;
      op_q         <= op_d;
      op1_q        <= op1_d;
      op2_q        <= op2_d;
      cnt_q        <= cnt_d;
      result_q     <= result_d;
      cmp_q        <= cmp_d;
    end
  end

  // Strobes are masked while reset is asserted so an aborted op never responds.
  always_comb begin
    req_ready  = '0;
    resp_valid = '0;
    if (rst_n && (state_q == ST_IDLE)) begin
      req_ready = grant;
    end
    if (rst_n && (state_q == ST_RESP)) begin
      resp_valid[idx_q] = 1'b1;
    end
  end

  assign busy        = (state_q != ST_IDLE);
  assign resp_result = result_q;
  assign resp_cmp    = cmp_q;

endmodule

`default_nettype wire

// File: tb/tb_fpu_share_ctrl.sv
// +----------------------------------------------------------------------+
// | tb_fpu_share_ctrl: directed vector table plus multi-cycle sequences. |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
`default_nettype none

module tb_fpu_share_ctrl;

  logic            clk = 1'b0;
  logic            rst_n;
  logic [3:0]      req_valid, req_ready, resp_valid;
  logic [3:0][3:0] req_op;
  logic [3:0][31:0] req_op1, req_op2;
  logic [31:0]     resp_result;
  logic            resp_cmp, busy;

  int n_cmp = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  fpu_share_ctrl #(.NUM_REQ(4), .DIV_CYCLES(4), .ALU_CYCLES(1)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .req_valid   (req_valid),
    .req_ready   (req_ready),
    .req_op      (req_op),
    .req_op1     (req_op1),
    .req_op2     (req_op2),
    .resp_valid  (resp_valid),
    .resp_result (resp_result),
    .resp_cmp    (resp_cmp),
    .busy        (busy)
  );

  typedef struct {
    int          req;
    logic [3:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    int          lat;
    logic [31:0] res;
    logic        cmp;
  } vec_t;

  vec_t vecs[13];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [3:0] exp_oh;
    int         got;

    vecs[0]  = '{0, 4'd1,  32'h3F800000, 32'h40000000, 2, 32'h40400000, 1'b0};
    vecs[1]  = '{1, 4'd4,  32'h40C00000, 32'h40000000, 5, 32'h40400000, 1'b0};
    vecs[2]  = '{2, 4'd8,  32'hBF800000, 32'h3F800000, 2, 32'h00000000, 1'b1};
    vecs[3]  = '{2, 4'd6,  32'h40490FDB, 32'h40490FDB, 2, 32'h00000000, 1'b1};
    vecs[4]  = '{3, 4'd15, 32'h3F800000, 32'h40000000, 2, 32'h00000000, 1'b0};
    vecs[5]  = '{0, 4'd2,  32'h40400000, 32'h3F800000, 2, 32'h40000000, 1'b0};
    vecs[6]  = '{1, 4'd5,  32'hC0400000, 32'h00000000, 2, 32'h40400000, 1'b0};
    vecs[7]  = '{3, 4'd7,  32'h3F800000, 32'h40000000, 2, 32'h00000000, 1'b1};
    vecs[8]  = '{0, 4'd3,  32'h40000000, 32'h40400000, 2, 32'h40C00000, 1'b0};
    vecs[9]  = '{1, 4'd0,  32'h40000000, 32'h40000000, 2, 32'h00000000, 1'b0};
    vecs[10] = '{2, 4'd8,  32'h3F800000, 32'hBF800000, 2, 32'h00000000, 1'b0};
    vecs[11] = '{3, 4'd4,  32'h3F800000, 32'h40000000, 5, 32'h3F000000, 1'b0};
    vecs[12] = '{0, 4'd3,  32'h40400000, 32'h00000000, 2, 32'h00000000, 1'b0};

    rst_n     = 1'b0;
    req_valid = '0;
    req_op    = '0;
    req_op1   = '0;
    req_op2   = '0;

    // Reset state, including ready masked while reset is held
    tick();
    tick();
    req_valid = 4'b0001;
    #1;
    chk("ready_in_reset", 64'(req_ready), 64'h0);
    tick();
    #1;
    chk("reset_outputs", {resp_valid, busy, resp_result, resp_cmp}, 64'h0);
    req_valid = '0;
    rst_n     = 1'b1;

    // FDIV on req 1 while the requester scribbles over its operands
    req_op[1]  = 4'd4;
    req_op1[1] = 32'h40C00000;
    req_op2[1] = 32'h40000000;
    req_valid  = 4'b0010;
    #1;
    chk("fdiv_grant", 64'(req_ready), 64'h2);
    for (int c = 1; c <= 4; c++) begin
      tick();
      req_op[1]  = 4'd1;
      req_op1[1] = $urandom;
      req_op2[1] = $urandom;
      #1;
      chk($sformatf("fdiv_exec_c%0d", c), 64'({req_ready, resp_valid, busy}), 64'({4'b0, 4'b0, 1'b1}));
    end
    tick();
    #1;
    chk("fdiv_resp", {resp_valid, resp_result, resp_cmp}, {4'b0010, 32'h40400000, 1'b0});
    req_valid = '0;
    tick();

    // Round-robin: all four hold FMUL after a fresh reset
    rst_n = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
    for (int r = 0; r < 4; r++) begin
      req_op[r]  = 4'd3;
      req_op1[r] = 32'h40000000;
      req_op2[r] = 32'h40400000;
    end
    req_valid = 4'hF;
    for (int c = 0; c < 15; c++) begin
      if (c > 0) tick();
      #1;
      exp_oh = 4'b0001 << ((c / 3) % 4);
      chk($sformatf("rr_ready_c%0d", c), 64'(req_ready), 64'((c % 3 == 0) ? exp_oh : 4'b0));
      chk($sformatf("rr_resp_c%0d", c), 64'(resp_valid), 64'((c % 3 == 2) ? exp_oh : 4'b0));
      if (c % 3 == 2) chk($sformatf("rr_result_c%0d", c), 64'(resp_result), 64'h40C00000);
      if (c == 14) req_valid = '0;
    end
    tick();

    // Reset during the second EXEC cycle of an FDIV
    req_op[2]  = 4'd4;
    req_op1[2] = 32'h40C00000;
    req_op2[2] = 32'h40000000;
    req_valid  = 4'b0100;
    #1;
    chk("abort_grant", 64'(req_ready), 64'h4);
    tick();
    req_valid = '0;
    tick();
    rst_n = 1'b0;
    #1;
    chk("abort_resp_in_rst", 64'(resp_valid), 64'h0);
    tick();
    rst_n = 1'b1;
    #1;
    chk("abort_outputs", {busy, resp_valid, req_ready, resp_result, resp_cmp}, 64'h0);
    for (int c = 0; c < 6; c++) begin
      tick();
      #1;
      chk($sformatf("abort_quiet_c%0d", c), 64'({resp_valid, busy}), 64'h0);
    end
    req_op[0]  = 4'd1;
    req_op1[0] = 32'h3F800000;
    req_op2[0] = 32'h40000000;
    req_op[1]  = 4'd1;
    req_valid  = 4'b0011;
    #1;
    chk("first_after_rst", 64'(req_ready), 64'h1);
    tick();
    req_valid = '0;
    tick();
    #1;
    chk("first_after_rst_resp", {resp_valid, resp_result}, {4'b0001, 32'h40400000});
    tick();

    // Vector table: one op at a time, latency, result, flag and hold
    for (int i = 0; i < 13; i++) begin
      req_op[vecs[i].req]  = vecs[i].op;
      req_op1[vecs[i].req] = vecs[i].a;
      req_op2[vecs[i].req] = vecs[i].b;
      req_valid            = 4'b0001 << vecs[i].req;
      #1;
      chk($sformatf("vec%0d_ready", i), 64'(req_ready), 64'(4'b0001 << vecs[i].req));
      got = -1;
      for (int k = 1; k <= 20; k++) begin
        tick();
        if (k == 1) req_valid = '0;
        #1;
        if (resp_valid != 4'b0) begin
          got = k;
          break;
        end
      end
      chk($sformatf("vec%0d_latency", i), 64'(got), 64'(vecs[i].lat));
      chk($sformatf("vec%0d_resp", i), {resp_valid, resp_result, resp_cmp},
          64'({4'b0001 << vecs[i].req, vecs[i].res, vecs[i].cmp}));
      tick();
      #1;
      chk($sformatf("vec%0d_hold", i), {busy, resp_valid, resp_result, resp_cmp},
          64'({1'b0, 4'b0, vecs[i].res, vecs[i].cmp}));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/fpu_share_ctrl.md
# fpu_share_ctrl

Shared-access controller for the single-cycle-combinational 32-bit floating-point ALU. It accepts operations from `NUM_REQ` requesters (cores/lanes) over valid/ready handshakes and picks one requester per operation by round-robin. It holds the selected operands stable at the ALU input for an op-dependent number of cycles, so FDIV can be constrained as a multicycle path. It then returns the result and compare flag to the winning requester as a one-cycle pulse.

## Interface

Parameters:
- `NUM_REQ`, default 4: number of requesters; 2 to 8.
- `DIV_CYCLES`, default 4: cycles operands are held for FDIV; must be ≥1.
- `ALU_CYCLES`, default 1: cycles operands are held for every other op; must be ≥1.

Ports (one clock; reset is synchronous and active-low):
- `clk`, input, 1: clock; all state changes on the rising edge.
- `rst_n`, input, 1: synchronous active-low reset.
- `req_valid`, input, `NUM_REQ`: per-requester operation valid.
- `req_ready`, output, `NUM_REQ`: one-hot; the grant/accept strobe.
- `req_op`, input, `NUM_REQ`×4: ALU opcode per requester.
- `req_op1`, input, `NUM_REQ`×32: operand 1 per requester.
- `req_op2`, input, `NUM_REQ`×32: operand 2 per requester.
- `resp_valid`, output, `NUM_REQ`: one-hot single-cycle response strobe.
- `resp_result`, output, 32: result, shared by all requesters.
- `resp_cmp`, output, 1: compare flag, shared by all requesters.
- `busy`, output, 1: high whenever the state is not IDLE.

## Operation

- FSM has three states: IDLE, EXEC, RESP.
- **IDLE**
  - If any `req_valid` is high, the arbiter selects index g, the first valid requester searching upward from `last_grant+1` with wrap-around.
  - `req_ready[g]` is asserted combinationally in that cycle; the handshake completes on that edge.
  - The op, op1, op2 and g are registered.
  - `cnt` loads `DIV_CYCLES-1` for op 4 (FDIV), otherwise `ALU_CYCLES-1`.
  - Next state is EXEC.
- **EXEC**
  - The ALU is driven only from the registered op and operands; these never change during EXEC.
  - If `cnt==0`, the ALU result and cmp are captured into the response registers and the next state is RESP.
  - Otherwise `cnt` decrements.
- **RESP**
  - `resp_valid[g]=1` for exactly one cycle. There is no backpressure; the requester must sample it.
  - `last_grant` is set to g; next state is IDLE.
- `req_ready` is all-zero outside IDLE. Requesters hold `req_valid` and their operands until their ready is seen.
- `resp_result` and `resp_cmp` hold their last captured value until the next capture.
  - Non-compare ops return cmp=0.
  - Compare ops (6–8) return result=0.
- Opcodes 0 and 9–15 are accepted and executed with `ALU_CYCLES` latency, returning result=0 and cmp=0. They are not an error.
- `cnt` width is `$clog2(max(DIV_CYCLES,ALU_CYCLES))`, with a minimum of 1 bit.
- A requester that deasserts `req_valid` before being granted is simply skipped.
- A requester granted in the RESP cycle is not possible, because grants only occur in IDLE.

## Timing

- Handshake in cycle 0. EXEC occupies cycles 1..N, where N is `DIV_CYCLES` or `ALU_CYCLES`. `resp_valid` is high in cycle N+1.
- The earliest next grant is cycle N+2. Throughput is one op per N+2 cycles.
- Reset values:
  - state = IDLE
  - `last_grant` = `NUM_REQ-1`, so requester 0 wins first
  - `cnt` = 0
  - `req_ready` = 0, `resp_valid` = 0
  - `resp_result` = 0, `resp_cmp` = 0
  - `busy` = 0
- Reset asserted mid-EXEC or in RESP discards the operation. No `resp_valid` is produced for it, including in the cycle reset is applied.
- Multicycle constraint: FDIV ALU paths may be constrained as `DIV_CYCLES` cycles. Operands are stable from the cycle-0 edge to the capture edge.

## Structure

- Shared package `fpu_pkg`:
  - opcode enum: FADD=1, FSUB=2, FMUL=3, FDIV=4, FABS=5, FEQ=6, FNE=7, FLT=8
  - FSM state enum
- One sub-module, `rr_arbiter`, parameterised by `NUM_REQ`:
  - Inputs: request vector and `last_grant`.
  - Outputs: one-hot grant and encoded index.
  - Purely combinational.
- The floating-point ALU is instantiated once inside this block.

## Test plan

- Req 0 sends FADD 0x3F800000 + 0x40000000 → `resp_valid[0]` in cycle 2 with `resp_result`=0x40400000 and `resp_cmp`=0.
- Req 1 sends FDIV 0x40C00000 / 0x40000000 with `DIV_CYCLES`=4 → `resp_valid[1]` in cycle 5 with result 0x40400000. ALU inputs stay unchanged in cycles 1–4 even while req 1 drives new operands.
- All 4 requesters hold FMUL 0x40000000 × 0x40400000 → grant order 0,1,2,3,0. Every response is 0x40C00000, and grants are 3 cycles apart.
- Req 2 sends FLT 0xBF800000 vs 0x3F800000 → cmp=1 and result=0. Then FEQ on identical operands → cmp=1.
- Reset asserted during the second EXEC cycle of an FDIV → no `resp_valid`, all outputs at reset values. The next request to req 0 is granted first.
- Opcode 0xF → accepted, response after `ALU_CYCLES`+1 cycles with result=0 and cmp=0.
